muldiv_hilo: RTL and testbench
==============================

# muldiv_hilo

Multi-cycle multiply/divide unit producing a HI/LO result pair for the MIPS pipeline's HI/LO data path. It accepts MULT, MULTU, DIV and DIVU operands from the execute stage and computes the result over several cycles. While computing, it holds the pipeline through `busy`. When finished, it presents HI/LO for writeback into the HI/LO register. It is parametrised in data width and supports signed and unsigned modes, with defined divide-by-zero and flush behaviour.

## Interface
Parameters:
- `WIDTH`, default 32, operand width. HI and LO are each `WIDTH` bits. Legal range is `WIDTH` ≥ 4.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high
- `start`  in  1  request; operands and `op` are sampled on the edge where `start`=1 and the unit is accepting
- `op`  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- `a`  in  WIDTH  multiplicand / dividend (rs)
- `b`  in  WIDTH  multiplier / divisor (rt)
- `flush`  in  1  synchronous cancel of the operation in flight
- `busy`  out  1  operation in progress; the pipeline stalls on this
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid from this cycle
- `hi`  out  WIDTH  MULT*: upper product half; DIV*: remainder
- `lo`  out  WIDTH  MULT*: lower product half; DIV*: quotient
- `dbz`  out  1  last completed divide had `b`=0; valid with and after `done`

## Operation
- FSM states: IDLE, MUL, DIV, DONE. All outputs are registered.
- **Accepting:** the unit accepts in IDLE or DONE. When `start`=1, `flush`=0:
  - latch operands;
  - convert to magnitudes if `op[0]`=0 (signed);
  - record result signs;
  - go to MUL (`op[1]`=0), DIV (`op[1]`=1, `b`≠0), or DONE (`op[1]`=1, `b`=0).
- **`start` while busy:** ignored; the operation in flight is unaffected.
- **MUL:** one cycle.
  - Forms the 2·WIDTH-bit magnitude product.
  - Negates it (two's complement over 2·WIDTH) when operand signs differ and the op is signed.
  - Loads `hi`/`lo`, then goes to DONE.
- **DIV:** exactly WIDTH cycles of restoring division, one quotient bit per cycle (MSB first).
  - Uses a WIDTH+1-bit partial remainder; the iteration counter runs 0..WIDTH-1.
  - After the last iteration, sign fix-up is applied in the same cycle:
    - quotient is negated if operand signs differ (signed);
    - remainder takes the dividend's sign.
  - Loads `lo`=quotient, `hi`=remainder, then goes to DONE.
- **Signed overflow:** most-negative ÷ −1 yields `lo`=most-negative, `hi`=0, `dbz`=0. No trap.
- **Divide by zero:** `lo`=all ones, `hi`=`a` (raw), `dbz`=1. No iterations are performed.
- **DONE:** `done`=1 for exactly one cycle. The next state is IDLE, or a new operation if `start`=1 (back-to-back is allowed).
- **Result hold:** `hi`, `lo` and `dbz` hold their values until the next completed operation. They never change mid-operation.
- **`flush`:**
  - In MUL or DIV, the next state is IDLE, `busy` drops, and no `done` is produced.
  - `hi`/`lo`/`dbz` keep their previous values.
  - `flush` and `start` together: flush wins and `start` is dropped.
  - `flush` in IDLE or DONE has no effect on results. The pending `done` pulse is still a single cycle.
- **Reset:** asynchronous, forces IDLE and `busy`=0, `done`=0, `hi`=0, `lo`=0, `dbz`=0. It aborts any operation in flight.

## Timing
- `start` sampled at the edge ending cycle t:
  - multiply: `busy`=1 in cycle t+1; `done`=1 in cycle t+2.
  - divide: `busy`=1 in cycles t+1..t+WIDTH; `done`=1 in cycle t+WIDTH+1.
  - divide by zero: `busy`=0 throughout; `done`=1 in cycle t+1.
- `busy` and `done` are never high in the same cycle.
- Back-to-back: a `start` in the `done` cycle produces the next `done` with the same latency, counted from that edge.
- `flush` asserted in cycle k with `busy`=1 gives `busy`=0 in cycle k+1.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `done` at t+2, `hi`=0xFFFFFFFE, `lo`=0x00000001; `busy` high exactly at t+1.
- MULT −3 × 5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. Then, starting in the `done` cycle, DIV −7 ÷ 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF, with `busy` for 32 cycles and `done` 33 cycles after the second `start`.
- DIV 0x80000000 ÷ 0xFFFFFFFF → `lo`=0x80000000, `hi`=0, `dbz`=0. DIVU 100 ÷ 0 → `done` at t+1, `lo`=0xFFFFFFFF, `hi`=100, `dbz`=1.
- DIVU 1000 ÷ 7; pulse `start` with new operands at t+5 (ignored); assert `flush` at t+10 → `busy`=0 at t+11, no `done` within 40 cycles, `hi`/`lo` retain prior values.
- Assert `rst` asynchronously mid-DIV (between clock edges) → `busy`, `done`, `hi`, `lo`, `dbz` all 0 before the next edge. After release, DIVU 9 ÷ 4 → `lo`=2, `hi`=1.
- With `WIDTH`=8: MULT 0x80 × 0x80 → `hi`=0x40, `lo`=0x00. DIV 0x81 ÷ 0x03 → `lo`=0xD6 (−42), `hi`=0xFF (−1), `done` at t+9.

Source files
------------

// File: rtl/muldiv_hilo.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit for the HI/LO path.
// Single-cycle multiply, WIDTH-cycle restoring divide, registered outputs.
module muldiv_hilo #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             dbz
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV,
      DONE
   } state_t;

   state_t state;
   state_t state_n;

   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH-1:0] quo;
   logic [WIDTH:0]   rem;
   logic [CW-1:0]    cnt;
   logic             neg_q;
   logic             neg_r;

   logic             accept;
   logic             is_signed;
   logic             b_zero;
   logic             last;
   logic [WIDTH-1:0] a_abs;
   logic [WIDTH-1:0] b_abs;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH+1:0] diff;
   logic [WIDTH:0]   rem_n;
   logic [WIDTH-1:0] quo_n;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   // Operand conditioning and the shared multiply / divide datapath.
   always_comb begin
      is_signed = ~op[0];
      b_zero    = (b == '0);
      accept    = start & ~flush & ((state == IDLE) | (state == DONE));
      a_abs     = (is_signed && a[WIDTH-1]) ? -a : a;
      b_abs     = (is_signed && b[WIDTH-1]) ? -b : b;
      last      = (cnt == CW'(WIDTH - 1));

      prod      = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
      prod_fix  = neg_q ? -prod : prod;

      rem_sh    = {rem[WIDTH-1:0], quo[WIDTH-1]};
      diff      = {1'b0, rem_sh} - {2'b00, mag_b};
      rem_n     = rem_sh;
      quo_n     = {quo[WIDTH-2:0], 1'b0};
      if (!diff[WIDTH+1]) begin
         rem_n = diff[WIDTH:0];
         quo_n = {quo[WIDTH-2:0], 1'b1};
      end

      q_fix     = neg_q ? -quo_n : quo_n;
      r_fix     = neg_r ? -rem_n[WIDTH-1:0] : rem_n[WIDTH-1:0];
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE, DONE: begin
            state_n = IDLE;
            if (accept) begin
               if (!op[1]) begin
                  state_n = MUL;
               end else if (b_zero) begin
                  state_n = DONE;
               end else begin
                  state_n = DIV;
               end
            end
         end
         MUL: begin
            state_n = flush ? IDLE : DONE;
         end
         DIV: begin
            if (flush) begin
               state_n = IDLE;
            end else if (last) begin
               state_n = DONE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         busy  <= (state_n == MUL) | (state_n == DIV);
         done  <= (state_n == DONE);
      end
   end

   // Results only move on a completed operation; flush leaves them alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mag_a <= '0;
         mag_b <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         rem   <= '0;
         quo   <= '0;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
         dbz   <= 1'b0;
      end else if (accept) begin
         mag_a <= a_abs;
         mag_b <= b_abs;
         neg_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
         neg_r <= is_signed & a[WIDTH-1];
         rem   <= '0;
         quo   <= a_abs;
         cnt   <= '0;
         if (op[1] && b_zero) begin
            hi  <= a;
            lo  <= '1;
            dbz <= 1'b1;
         end
      end else if (state == MUL && !flush) begin
         hi  <= prod_fix[2*WIDTH-1:WIDTH];
         lo  <= prod_fix[WIDTH-1:0];
         dbz <= 1'b0;
      end else if (state == DIV && !flush) begin
         rem <= rem_n;
         quo <= quo_n;
         cnt <= cnt + CW'(1);
         if (last) begin
            hi  <= r_fix;
            lo  <= q_fix;
            dbz <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed self-checking bench for muldiv_hilo.
// Covers 32-bit and 8-bit instances with hand-computed results.
module tb_muldiv_hilo;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        dbz;

   logic        start8;
   logic [1:0]  op8;
   logic [7:0]  a8;
   logic [7:0]  b8;
   logic        flush8;
   logic        busy8;
   logic        done8;
   logic [7:0]  hi8;
   logic [7:0]  lo8;
   logic        dbz8;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   muldiv_hilo #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo), .dbz(dbz)
   );

   muldiv_hilo #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
      .flush(flush8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8),
      .dbz(dbz8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input int limit,
                         output int lat, output int bcnt);
      op = o; a = x; b = y; start = 1'b1;
      tick();
      start = 1'b0;
      lat = 1; bcnt = 0;
      while (!done && lat < limit) begin
         if (busy) bcnt++;
         tick();
         lat++;
      end
      if (!done) lat = -1;
   endtask

   task automatic run_op8(input logic [1:0] o, input logic [7:0] x,
                          input logic [7:0] y, input int limit,
                          output int lat);
      op8 = o; a8 = x; b8 = y; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      lat = 1;
      while (!done8 && lat < limit) begin
         tick();
         lat++;
      end
      if (!done8) lat = -1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 0; flush = 0; op = 0; a = 0; b = 0;
      start8 = 0; flush8 = 0; op8 = 0; a8 = 0; b8 = 0;
      repeat (2) tick();
      total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
      total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
      total++; if (hi !== 32'h0) $display("FAIL reset_hi got %h want 0", hi); else passed++;
      total++; if (lo !== 32'h0) $display("FAIL reset_lo got %h want 0", lo); else passed++;
      total++; if (dbz !== 1'b0) $display("FAIL reset_dbz got %b want 0", dbz); else passed++;
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_multu();
      op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
      tick();
      start = 1'b0;
      total++; if (busy !== 1'b1) $display("FAIL multu_busy_t1 got %b want 1", busy); else passed++;
      total++; if (done !== 1'b0) $display("FAIL multu_done_t1 got %b want 0", done); else passed++;
      tick();
      total++; if (done !== 1'b1) $display("FAIL multu_done_t2 got %b want 1", done); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL multu_busy_t2 got %b want 0", busy); else passed++;
      total++; if (hi !== 32'hFFFF_FFFE) $display("FAIL multu_hi got %h want fffffffe", hi); else passed++;
      total++; if (lo !== 32'h0000_0001) $display("FAIL multu_lo got %h want 00000001", lo); else passed++;
      tick();
      total++; if (done !== 1'b0) $display("FAIL multu_done_t3 got %b want 0", done); else passed++;
   endtask

   task automatic test_back_to_back();
      int lat, bc;
      run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 10, lat, bc);
      total++; if (lat !== 2) $display("FAIL mult_lat got %0d want 2", lat); else passed++;
      total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi got %h want ffffffff", hi); else passed++;
      total++; if (lo !== 32'hFFFF_FFF1) $display("FAIL mult_lo got %h want fffffff1", lo); else passed++;
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 60, lat, bc);
      total++; if (bc !== 32) $display("FAIL div_busy_cycles got %0d want 32", bc); else passed++;
      total++; if (lat !== 33) $display("FAIL div_lat got %0d want 33", lat); else passed++;
      total++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_lo got %h want fffffffd", lo); else passed++;
      total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL div_hi got %h want ffffffff", hi); else passed++;
   endtask

   task automatic test_div_overflow();
      int lat, bc;
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 60, lat, bc);
      total++; if (lat !== 33) $display("FAIL ovf_lat got %0d want 33", lat); else passed++;
      total++; if (lo !== 32'h8000_0000) $display("FAIL ovf_lo got %h want 80000000", lo); else passed++;
      total++; if (hi !== 32'h0) $display("FAIL ovf_hi got %h want 0", hi); else passed++;
      total++; if (dbz !== 1'b0) $display("FAIL ovf_dbz got %b want 0", dbz); else passed++;
   endtask

   task automatic test_busy_start();
      int cyc;
      op = 2'b11; a = 32'd1000; b = 32'd7; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      op = 2'b01; a = 32'd5; b = 32'd5; start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 6;
      while (!done && cyc < 60) begin
         tick();
         cyc++;
      end
      total++; if (cyc !== 33) $display("FAIL busy_start_lat got %0d want 33", cyc); else passed++;
      total++; if (lo !== 32'd142) $display("FAIL busy_start_lo got %0d want 142", lo); else passed++;
      total++; if (hi !== 32'd6) $display("FAIL busy_start_hi got %0d want 6", hi); else passed++;
      total++; if (dbz !== 1'b0) $display("FAIL busy_start_dbz got %b want 0", dbz); else passed++;
   endtask

   task automatic test_dbz();
      int lat, bc;
      run_op(2'b11, 32'd100, 32'd0, 10, lat, bc);
      total++; if (lat !== 1) $display("FAIL dbz_lat got %0d want 1", lat); else passed++;
      total++; if (bc !== 0) $display("FAIL dbz_busy got %0d want 0", bc); else passed++;
      total++; if (lo !== 32'hFFFF_FFFF) $display("FAIL dbz_lo got %h want ffffffff", lo); else passed++;
      total++; if (hi !== 32'd100) $display("FAIL dbz_hi got %0d want 100", hi); else passed++;
      total++; if (dbz !== 1'b1) $display("FAIL dbz_flag got %b want 1", dbz); else passed++;
   endtask

   task automatic test_flush();
      logic seen;
      op = 2'b11; a = 32'd1000; b = 32'd7; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      op = 2'b11; a = 32'd55; b = 32'd3; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      total++; if (busy !== 1'b1) $display("FAIL flush_pre_busy got %b want 1", busy); else passed++;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      total++; if (busy !== 1'b0) $display("FAIL flush_busy got %b want 0", busy); else passed++;
      seen = 1'b0;
      repeat (40) begin
         if (done) seen = 1'b1;
         tick();
      end
      total++; if (seen !== 1'b0) $display("FAIL flush_no_done got %b want 0", seen); else passed++;
      total++; if (hi !== 32'd100) $display("FAIL flush_hi got %0d want 100", hi); else passed++;
      total++; if (lo !== 32'hFFFF_FFFF) $display("FAIL flush_lo got %h want ffffffff", lo); else passed++;
      total++; if (dbz !== 1'b1) $display("FAIL flush_dbz got %b want 1", dbz); else passed++;
   endtask

   task automatic test_async_reset();
      int lat, bc;
      op = 2'b11; a = 32'd1000; b = 32'd7; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      total++; if (busy !== 1'b1) $display("FAIL arst_pre_busy got %b want 1", busy); else passed++;
      #2;
      rst = 1'b1;
      #1;
      total++; if (busy !== 1'b0) $display("FAIL arst_busy got %b want 0", busy); else passed++;
      total++; if (done !== 1'b0) $display("FAIL arst_done got %b want 0", done); else passed++;
      total++; if (hi !== 32'h0) $display("FAIL arst_hi got %h want 0", hi); else passed++;
      total++; if (lo !== 32'h0) $display("FAIL arst_lo got %h want 0", lo); else passed++;
      total++; if (dbz !== 1'b0) $display("FAIL arst_dbz got %b want 0", dbz); else passed++;
      @(negedge clk);
      rst = 1'b0;
      tick();
      run_op(2'b11, 32'd9, 32'd4, 60, lat, bc);
      total++; if (lat !== 33) $display("FAIL divu94_lat got %0d want 33", lat); else passed++;
      total++; if (lo !== 32'd2) $display("FAIL divu94_lo got %0d want 2", lo); else passed++;
      total++; if (hi !== 32'd1) $display("FAIL divu94_hi got %0d want 1", hi); else passed++;
   endtask

   task automatic test_width8();
      int lat;
      run_op8(2'b00, 8'h80, 8'h80, 10, lat);
      total++; if (lat !== 2) $display("FAIL w8_mult_lat got %0d want 2", lat); else passed++;
      total++; if (hi8 !== 8'h40) $display("FAIL w8_mult_hi got %h want 40", hi8); else passed++;
      total++; if (lo8 !== 8'h00) $display("FAIL w8_mult_lo got %h want 00", lo8); else passed++;
      run_op8(2'b10, 8'h81, 8'h03, 20, lat);
      total++; if (lat !== 9) $display("FAIL w8_div_lat got %0d want 9", lat); else passed++;
      total++; if (lo8 !== 8'hD6) $display("FAIL w8_div_lo got %h want d6", lo8); else passed++;
      total++; if (hi8 !== 8'hFF) $display("FAIL w8_div_hi got %h want ff", hi8); else passed++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_multu();
      test_back_to_back();
      test_div_overflow();
      test_busy_start();
      test_dbz();
      test_flush();
      test_async_reset();
      test_width8();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
